// File: rtl/sqrt_pkg.sv
// Shared sizing rules for the pipelined integer square root.
// Latency: n/a (elaboration-time helpers only).
// Backpressure: n/a.
//
// Package sqrt_pkg
//   sqrt_out_w : root width derived from the radicand width
//   sqrt_nstg  : pipeline depth (= latency in cycles)
//   sqrt_rem_w : width of the partial remainder carried between stages
package sqrt_pkg;

    // Root width: a W-bit radicand has a root of at most W/2 bits.
    function automatic int sqrt_out_w(input int in_w);
        return in_w / 2;
    endfunction

    // One stage resolves bps root bits, so depth is root width / bps.
    function automatic int sqrt_nstg(input int in_w, input int bps);
        return (in_w / 2) / bps;
    endfunction

    // Partial remainder never exceeds 2*q, but the shifted trial value
    // (r<<2 | pair) needs two more bits than the root.
    function automatic int sqrt_rem_w(input int out_w);
        return out_w + 2;
    endfunction

endpackage

// File: rtl/sqrt_stage.sv
// One pipeline slot: BPS restoring square-root iterations then a register.
// Latency: 1 cycle.
// Backpressure: registers load only when i_adv is high, otherwise hold (bubbles too).
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   i_adv               : global advance from the top-level handshake
//   i_vld/i_rad/i_rem/i_root : incoming slot (valid, unconsumed radicand
//                         bits left-aligned, partial remainder, partial root)
//   o_vld/o_rad/o_rem/o_root : registered slot after BPS more root bits
//
// With SQRT_REMAINDER_EN undefined the last stage keeps no remainder
// register; o_rem is then tied to zero.
module sqrt_stage
    import sqrt_pkg::*;
#(
    parameter int  IN_W  = 16,
    parameter int  BPS   = 1,
    parameter bit  LAST  = 1'b0,
    localparam int OUT_W = sqrt_out_w(IN_W),
    localparam int REM_W = sqrt_rem_w(OUT_W)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_vld,
    input  logic [IN_W-1:0]  i_rad,
    input  logic [REM_W-1:0] i_rem,
    input  logic [OUT_W-1:0] i_root,
    output logic             o_vld,
    output logic [IN_W-1:0]  o_rad,
    output logic [REM_W-1:0] o_rem,
    output logic [OUT_W-1:0] o_root
);

    typedef struct packed {
        logic [IN_W-1:0]  rad;
        logic [REM_W-1:0] rem;
        logic [OUT_W-1:0] root;
    } payload_t;

    payload_t           w_nxt;
    logic [REM_W-1:0]   w_r_sh;
    logic [REM_W-1:0]   w_q_sh;
    logic [REM_W:0]     w_t;

    // Restoring digit recurrence. The radicand is kept left-aligned so the
    // next pair is always the top two bits; shifting left consumes it.
    // Top bits dropped by the shifts are zero by the r <= 2q invariant.
    always_comb begin
        w_nxt.rad  = i_rad;
        w_nxt.rem  = i_rem;
        w_nxt.root = i_root;
        w_r_sh     = '0;
        w_q_sh     = '0;
        w_t        = '0;
        for (int k = 0; k < BPS; k++) begin
            w_r_sh    = (w_nxt.rem << 2) | REM_W'(w_nxt.rad[IN_W-1 -: 2]);
            w_q_sh    = (REM_W'(w_nxt.root) << 2) | REM_W'(1);
            // One extra MSB so the borrow shows up as a sign bit.
            w_t       = {1'b0, w_r_sh} - {1'b0, w_q_sh};
            w_nxt.rad = w_nxt.rad << 2;
            if (!w_t[REM_W]) begin
                w_nxt.rem  = w_t[REM_W-1:0];
                w_nxt.root = (w_nxt.root << 1) | OUT_W'(1);
            end else begin
                w_nxt.rem  = w_r_sh;
                w_nxt.root = w_nxt.root << 1;
            end
        end
    end

    logic             r_vld;
    logic [OUT_W-1:0] r_root;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_root <= '0;
        end else if (i_adv) begin
            r_vld  <= i_vld;
            r_root <= w_nxt.root;
        end
    end

    assign o_vld  = r_vld;
    assign o_root = r_root;

    generate
        if (LAST) begin : g_last
            // Nothing downstream consumes radicand bits after the last stage.
            assign o_rad = '0;
`ifdef SQRT_REMAINDER_EN
            logic [REM_W-1:0] r_rem;
            logic             w_unused;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rem <= '0;
                end else if (i_adv) begin
                    r_rem <= w_nxt.rem;
                end
            end

            assign o_rem    = r_rem;
            assign w_unused = ^w_nxt.rad;
`else
            logic w_unused;

            assign o_rem    = '0;
            assign w_unused = ^{w_nxt.rad, w_nxt.rem};
`endif
        end else begin : g_mid
            logic [IN_W-1:0]  r_rad;
            logic [REM_W-1:0] r_rem;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rad <= '0;
                    r_rem <= '0;
                end else if (i_adv) begin
                    r_rad <= w_nxt.rad;
                    r_rem <= w_nxt.rem;
                end
            end

            assign o_rad = r_rad;
            assign o_rem = r_rem;
        end
    endgenerate

endmodule

// File: rtl/sqrt_pipe_param.sv
// Fully pipelined floor(sqrt(x)), IN_W-bit radicand, BPS root bits per stage.
// Latency: NSTG = (IN_W/2)/BPS cycles, throughput one operand per cycle.
// Backpressure: whole pipe freezes while valid_o & ~ready_i; ready_o low exactly then.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   valor_i, valid_i  : radicand in, accepted when valid_i & ready_o
//   ready_o           : combinational, = ~valid_o | ready_i
//   root_o, valid_o   : root out, handed off when valid_o & ready_i
//   ready_i           : consumer ready
//   rem_o             : valor_i - root_o^2, present only with SQRT_REMAINDER_EN
// Optional macro: SQRT_REMAINDER_EN adds rem_o and the final remainder register.
module sqrt_pipe_param
    import sqrt_pkg::*;
#(
    parameter int  IN_W  = 16,
    parameter int  BPS   = 1,
    localparam int OUT_W = sqrt_out_w(IN_W),
    localparam int NSTG  = sqrt_nstg(IN_W, BPS),
    localparam int REM_W = sqrt_rem_w(OUT_W)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  valor_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] root_o,
    output logic             valid_o,
    input  logic             ready_i
`ifdef SQRT_REMAINDER_EN
    ,
    output logic [OUT_W:0]   rem_o
`endif
);

    generate
        if ((IN_W % 2) != 0 || IN_W < 4 || IN_W > 32 ||
            !(BPS == 1 || BPS == 2 || BPS == 4) || (OUT_W % BPS) != 0) begin : g_param_err
            $error("sqrt_pipe_param: IN_W must be even in 4..32 and BPS in {1,2,4} dividing IN_W/2");
        end
    endgenerate

    // Slot k is the input of stage k; slot NSTG is the output register.
    logic             w_vld  [0:NSTG];
    logic [IN_W-1:0]  w_rad  [0:NSTG];
    logic [REM_W-1:0] w_rem  [0:NSTG];
    logic [OUT_W-1:0] w_root [0:NSTG];
    logic             w_adv;

    // Single global enable: no bubble collapsing, so a stall freezes every
    // slot and the accept-to-result distance stays exactly NSTG cycles.
    assign w_adv   = ~w_vld[NSTG] | ready_i;
    assign ready_o = w_adv;

    assign w_vld[0]  = valid_i;
    assign w_rad[0]  = valor_i;
    assign w_rem[0]  = '0;
    assign w_root[0] = '0;

    generate
        for (genvar g = 0; g < NSTG; g++) begin : g_stg
            sqrt_stage #(
                .IN_W (IN_W),
                .BPS  (BPS),
                .LAST (g == NSTG - 1)
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_adv  (w_adv),
                .i_vld  (w_vld[g]),
                .i_rad  (w_rad[g]),
                .i_rem  (w_rem[g]),
                .i_root (w_root[g]),
                .o_vld  (w_vld[g+1]),
                .o_rad  (w_rad[g+1]),
                .o_rem  (w_rem[g+1]),
                .o_root (w_root[g+1])
            );
        end
    endgenerate

    assign valid_o = w_vld[NSTG];
    assign root_o  = w_root[NSTG];

`ifdef SQRT_REMAINDER_EN
    logic w_unused;

    // Final remainder is at most 2*root, so its top bit is always zero.
    assign rem_o    = w_rem[NSTG][OUT_W:0];
    assign w_unused = ^{w_rad[NSTG], w_rem[NSTG][REM_W-1]};
`else
    logic w_unused;

    assign w_unused = ^{w_rad[NSTG], w_rem[NSTG]};
`endif

endmodule

// File: tb/tb_sqrt_pipe_param.sv
// Bench for sqrt_pipe_param: 16-bit/BPS=1 instance (a_*) and 32-bit/BPS=4 instance (b_*).
// Latency: n/a.
// Backpressure: random ready_i in one scenario.
module tb_sqrt_pipe_param;

    logic        clk;
    logic        rst_n;

    logic [15:0] a_valor;
    logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i;
    logic [7:0]  a_root;
    logic [31:0] b_valor;
    logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    logic [15:0] b_root;
`ifdef SQRT_REMAINDER_EN
    logic [8:0]  a_rem;
    logic [16:0] b_rem;
`endif

    int errors = 0;
    int checks = 0;

    sqrt_pipe_param #(.IN_W(16), .BPS(1)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .valor_i (a_valor),
        .valid_i (a_valid_i),
        .ready_o (a_ready_o),
        .root_o  (a_root),
        .valid_o (a_valid_o),
        .ready_i (a_ready_i)
`ifdef SQRT_REMAINDER_EN
        ,
        .rem_o   (a_rem)
`endif
    );

    sqrt_pipe_param #(.IN_W(32), .BPS(4)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .valor_i (b_valor),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .root_o  (b_root),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i)
`ifdef SQRT_REMAINDER_EN
        ,
        .rem_o   (b_rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference by binary search on squares (independent of the digit recurrence).
    function automatic longint ref_root(input longint x);
        longint lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid_i = 1'b0; a_valor = '0; a_ready_i = 1'b0;
        b_valid_i = 1'b0; b_valor = '0; b_ready_i = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %b expected 0", a_valid_o); end
        checks++; if (a_root !== 8'd0) begin errors++; $display("FAIL reset_root_o: got %0d expected 0", a_root); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o: got %b expected 1", a_ready_o); end
        checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o_wide: got %b expected 0", b_valid_o); end
`ifdef SQRT_REMAINDER_EN
        checks++; if (a_rem !== 9'd0) begin errors++; $display("FAIL reset_rem_o: got %0d expected 0", a_rem); end
`endif
    endtask

    task automatic test_directed();
        logic [15:0] xv [4];
        logic [7:0]  rv [4];
        logic [8:0]  mv [4];
        int lat;
        xv = '{16'd0, 16'd144, 16'd145, 16'd65535};
        rv = '{8'd0, 8'd12, 8'd12, 8'd255};
        mv = '{9'd0, 9'd0, 9'd1, 9'd510};
        a_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_valor = xv[i];
            a_valid_i = 1'b1;
            step();
            a_valid_i = 1'b0;
            lat = 1;
            while (!a_valid_o && lat < 20) begin
                step();
                lat++;
            end
            checks++; if (lat !== 8) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 8", i, lat); end
            checks++; if (a_root !== rv[i]) begin errors++; $display("FAIL directed_root[%0d]: got %0d expected %0d", i, a_root, rv[i]); end
`ifdef SQRT_REMAINDER_EN
            checks++; if (a_rem !== mv[i]) begin errors++; $display("FAIL directed_rem[%0d]: got %0d expected %0d", i, a_rem, mv[i]); end
`endif
            step();
        end
    endtask

    task automatic test_back_to_back();
        int rcv;
        longint r;
        rcv = 0;
        a_ready_i = 1'b1;
        for (int c = 0; c < 1100 && rcv < 1024; c++) begin
            if (a_valid_o) begin
                r = ref_root(longint'(rcv));
                checks++; if (c !== rcv + 8) begin errors++; $display("FAIL b2b_timing[%0d]: got cycle %0d expected %0d", rcv, c, rcv + 8); end
                checks++; if (a_root !== 8'(r)) begin errors++; $display("FAIL b2b_root[%0d]: got %0d expected %0d", rcv, a_root, r); end
`ifdef SQRT_REMAINDER_EN
                checks++; if (a_rem !== 9'(rcv - r * r)) begin errors++; $display("FAIL b2b_rem[%0d]: got %0d expected %0d", rcv, a_rem, rcv - r * r); end
`endif
                rcv++;
            end
            a_valid_i = (c < 1024);
            a_valor   = 16'(c);
            step();
        end
        a_valid_i = 1'b0;
        checks++; if (rcv !== 1024) begin errors++; $display("FAIL b2b_count: got %0d expected 1024", rcv); end
    endtask

    task automatic test_backpressure();
        int sent, rcv;
        logic held;
        logic [7:0] held_root;
`ifdef SQRT_REMAINDER_EN
        logic [8:0] held_rem;
`endif
        longint r;
        sent = 0; rcv = 0; held = 1'b0; held_root = '0;
        for (int c = 0; c < 6000 && rcv < 1024; c++) begin
            if (held) begin
                checks++; if (a_valid_o !== 1'b1 || a_root !== held_root) begin errors++; $display("FAIL bp_hold: got valid %b root %0d expected valid 1 root %0d", a_valid_o, a_root, held_root); end
`ifdef SQRT_REMAINDER_EN
                checks++; if (a_rem !== held_rem) begin errors++; $display("FAIL bp_hold_rem: got %0d expected %0d", a_rem, held_rem); end
`endif
            end
            a_ready_i = 1'($urandom_range(0, 1));
            a_valid_i = (sent < 1024);
            a_valor   = 16'(sent);
            #1;
            checks++; if (a_ready_o !== !(a_valid_o && !a_ready_i)) begin errors++; $display("FAIL bp_ready_o: got %b expected %b", a_ready_o, !(a_valid_o && !a_ready_i)); end
            if (a_valid_o && a_ready_i) begin
                r = ref_root(longint'(rcv));
                checks++; if (a_root !== 8'(r)) begin errors++; $display("FAIL bp_root[%0d]: got %0d expected %0d", rcv, a_root, r); end
`ifdef SQRT_REMAINDER_EN
                checks++; if (a_rem !== 9'(rcv - r * r)) begin errors++; $display("FAIL bp_rem[%0d]: got %0d expected %0d", rcv, a_rem, rcv - r * r); end
`endif
                rcv++;
            end
            held = a_valid_o && !a_ready_i;
            held_root = a_root;
`ifdef SQRT_REMAINDER_EN
            held_rem = a_rem;
`endif
            if (a_valid_i && a_ready_o) sent++;
            step();
        end
        a_valid_i = 1'b0;
        a_ready_i = 1'b1;
        checks++; if (rcv !== 1024) begin errors++; $display("FAIL bp_count: got %0d expected 1024", rcv); end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_reset_midflight();
        int stray, hit;
        a_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_valid_i = 1'b1;
            a_valor = 16'(100 + i);
            step();
        end
        a_valid_i = 1'b0;
        rst_n = 1'b0;
        step();
        checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid_o: got %b expected 0", a_valid_o); end
        rst_n = 1'b1;
        a_valid_i = 1'b1;
        a_valor = 16'd81;
        step();
        a_valid_i = 1'b0;
        stray = 0; hit = 0;
        for (int n = 1; n <= 16; n++) begin
            if (a_valid_o) begin
                if (n == 8 && a_root == 8'd9) hit++;
                else stray++;
            end
            step();
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL midreset_stray: got %0d unexpected results expected 0", stray); end
        checks++; if (hit !== 1) begin errors++; $display("FAIL midreset_root81: got %0d hits expected 1", hit); end
    endtask

    task automatic test_wide();
        logic [31:0] xv [8];
        logic [15:0] rv [8];
        logic [16:0] mv [8];
        logic [31:0] q [$];
        logic [31:0] x;
        longint r;
        int lat, rcv;
        xv = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd4294836225, 32'd4294836224, 32'd2, 32'd3, 32'd4};
        rv = '{16'd65535, 16'd0, 16'd1, 16'd65535, 16'd65534, 16'd1, 16'd1, 16'd2};
        mv = '{17'd131070, 17'd0, 17'd0, 17'd0, 17'd131068, 17'd1, 17'd2, 17'd0};
        b_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_valor = xv[i];
            b_valid_i = 1'b1;
            step();
            b_valid_i = 1'b0;
            lat = 1;
            while (!b_valid_o && lat < 20) begin
                step();
                lat++;
            end
            checks++; if (lat !== 4) begin errors++; $display("FAIL wide_latency[%0d]: got %0d expected 4", i, lat); end
            checks++; if (b_root !== rv[i]) begin errors++; $display("FAIL wide_root[%0d]: got %0d expected %0d", i, b_root, rv[i]); end
`ifdef SQRT_REMAINDER_EN
            checks++; if (b_rem !== mv[i]) begin errors++; $display("FAIL wide_rem[%0d]: got %0d expected %0d", i, b_rem, mv[i]); end
`endif
            step();
        end
        rcv = 0;
        for (int c = 0; c < 2100 && rcv < 2000; c++) begin
            if (b_valid_o) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL wide_rand_extra: got unexpected result %0d expected none", b_root);
                end else begin
                    x = q.pop_front();
                    r = ref_root(longint'(x));
                    checks++; if (b_root !== 16'(r)) begin errors++; $display("FAIL wide_rand_root x=%0d: got %0d expected %0d", x, b_root, r); end
`ifdef SQRT_REMAINDER_EN
                    checks++; if (b_rem !== 17'(longint'(x) - r * r)) begin errors++; $display("FAIL wide_rand_rem x=%0d: got %0d expected %0d", x, b_rem, longint'(x) - r * r); end
`endif
                end
                rcv++;
            end
            b_valid_i = (c < 2000);
            b_valor = $urandom;
            if (c < 2000) q.push_back(b_valor);
            step();
        end
        b_valid_i = 1'b0;
        checks++; if (rcv !== 2000) begin errors++; $display("FAIL wide_rand_count: got %0d expected 2000", rcv); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
